// File: rtl/stripes_sip_array_ctrl_if.sv
// Bundle between the NBin/SB fetch side and the SIP array controller: start/config,
// bit-plane stream, synapse and bias words, and the NBout drain handshake.
interface stripes_sip_array_ctrl_if #(
  parameter int N  = 16,
  parameter int Tn = 4,
  parameter int Tw = 16,
  parameter int Ti = 16,
  parameter int PW = 5
);
  localparam int FW = (Tn > 1) ? $clog2(Tn) : 1;

  logic                 i_start;
  logic [PW-1:0]        i_precision;
  logic                 i_signed;
  logic                 i_bits_valid;
  logic [Tw*Ti-1:0]     i_bits;
  logic [N*Ti*Tn-1:0]   i_synapses;
  logic [N*Tn*Tw-1:0]   i_nbout;
  logic                 i_ready;
  logic                 o_busy;
  logic                 o_err;
  logic                 o_valid;
  logic [FW-1:0]        o_filt;
  logic [N*Tw-1:0]      o_to_bus;

  modport master (
    output i_start, i_precision, i_signed, i_bits_valid, i_bits, i_synapses, i_nbout, i_ready,
    input  o_busy, o_err, o_valid, o_filt, o_to_bus
  );

  modport slave (
    input  i_start, i_precision, i_signed, i_bits_valid, i_bits, i_synapses, i_nbout, i_ready,
    output o_busy, o_err, o_valid, o_filt, o_to_bus
  );
endinterface

// File: rtl/stripes_sip_array_ctrl.sv
// Tn x Tw array of serial inner-product units: precision-counting FSM, bit-plane
// accumulation, NBout bias add with saturation, and a one-filter-per-beat drain.
module stripes_sip_array_ctrl #(
  parameter int N     = 16,
  parameter int Tn    = 4,
  parameter int Tw    = 16,
  parameter int Ti    = 16,
  parameter int PW    = 5,
  parameter int ACC_W = 2*N+4
) (
  input  logic clk,
  input  logic reset,
  stripes_sip_array_ctrl_if.slave sif
);
  // state | meaning
  // IDLE  | waiting for a start with a legal precision
  // ACCUM | consuming P activation bit-planes, MSB first
  // DRAIN | presenting one filter of saturated results per beat
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN} state_t;

  localparam int FW = (Tn > 1) ? $clog2(Tn) : 1;
  localparam int SW = ACC_W + 1;
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-N+1){1'b1}}, {(N-1){1'b0}}};

  state_t                  state_q, state_d;
  logic [PW-1:0]           prec_q, prec_d, k_q, k_d;
  logic                    sgn_q, sgn_d;
  logic [N*Tn*Tw-1:0]      nbout_q, nbout_d;
  logic                    valid_q, valid_d, err_q, err_d;
  logic [FW-1:0]           filt_q, filt_d;
  logic [N*Tw-1:0]         bus_q, bus_d;
  logic signed [ACC_W-1:0] acc_q [Tn][Tw];
  logic signed [ACC_W-1:0] acc_d [Tn][Tw];
  logic signed [ACC_W-1:0] part  [Tn][Tw];
  logic [N*Tw-1:0]         row_res;
  logic                    start_ok, plane_en;

  assign start_ok = sif.i_start && (sif.i_precision != '0) && (int'(sif.i_precision) <= N);
  assign plane_en = (state_q == S_ACCUM) && sif.i_bits_valid;

  always_comb begin
    for (int f = 0; f < Tn; f++) begin
      for (int w = 0; w < Tw; w++) begin
        part[f][w] = '0;
        for (int i = 0; i < Ti; i++) begin
          if (sif.i_bits[w*Ti+i])
            part[f][w] = part[f][w] + ACC_W'($signed(sif.i_synapses[(f*Ti+i)*N +: N]));
        end
      end
    end
  end

  // The first plane of a two's-complement activation carries negative weight.
  always_comb begin
    for (int f = 0; f < Tn; f++) begin
      for (int w = 0; w < Tw; w++) begin
        acc_d[f][w] = acc_q[f][w];
        if (state_q == S_IDLE && start_ok)
          acc_d[f][w] = '0;
        else if (plane_en) begin
          if (k_q == '0 && sgn_q)
            acc_d[f][w] = (acc_q[f][w] <<< 1) - part[f][w];
          else
            acc_d[f][w] = (acc_q[f][w] <<< 1) + part[f][w];
        end
      end
    end
  end

  // Row for the next registered beat: filter 0 straight from the final plane's
  // accumulator update, otherwise the filter after the one on the bus.
  always_comb begin
    int                      row;
    logic signed [ACC_W-1:0] a;
    logic signed [N-1:0]     b;
    logic signed [SW-1:0]    sum;
    row = (state_q == S_DRAIN) ? int'(filt_q) + 1 : 0;
    if (row >= Tn) row = 0;
    row_res = '0;
    for (int w = 0; w < Tw; w++) begin
      a = '0;
      b = '0;
      for (int f = 0; f < Tn; f++) begin
        if (f == row) begin
          a = (state_q == S_ACCUM) ? acc_d[f][w] : acc_q[f][w];
          b = nbout_q[(f*Tw+w)*N +: N];
        end
      end
      sum = SW'(a) + SW'(b);
      if (sum > SAT_MAX)      row_res[w*N +: N] = SAT_MAX[N-1:0];
      else if (sum < SAT_MIN) row_res[w*N +: N] = SAT_MIN[N-1:0];
      else                    row_res[w*N +: N] = sum[N-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    prec_d  = prec_q;
    sgn_d   = sgn_q;
    k_d     = k_q;
    nbout_d = nbout_q;
    valid_d = valid_q;
    filt_d  = filt_q;
    bus_d   = bus_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (sif.i_start) begin
          if (start_ok) begin
            prec_d  = sif.i_precision;
            sgn_d   = sif.i_signed;
            nbout_d = sif.i_nbout;
            k_d     = '0;
            state_d = S_ACCUM;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_ACCUM: begin
        if (sif.i_bits_valid) begin
          k_d = k_q + 1'b1;
          if (k_q == prec_q - 1'b1) begin
            state_d = S_DRAIN;
            valid_d = 1'b1;
            filt_d  = '0;
            bus_d   = row_res;
          end
        end
      end
      S_DRAIN: begin
        if (sif.i_ready) begin
          if (int'(filt_q) == Tn-1) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            filt_d  = '0;
            bus_d   = '0;
          end else begin
            filt_d = filt_q + 1'b1;
            bus_d  = row_res;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      prec_q  <= '0;
      sgn_q   <= 1'b0;
      k_q     <= '0;
      nbout_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      filt_q  <= '0;
      bus_q   <= '0;
      for (int f = 0; f < Tn; f++)
        for (int w = 0; w < Tw; w++)
          acc_q[f][w] <= '0;
    end else begin
      state_q <= state_d;
      prec_q  <= prec_d;
      sgn_q   <= sgn_d;
      k_q     <= k_d;
      nbout_q <= nbout_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      filt_q  <= filt_d;
      bus_q   <= bus_d;
      for (int f = 0; f < Tn; f++)
        for (int w = 0; w < Tw; w++)
          acc_q[f][w] <= acc_d[f][w];
    end
  end

  assign sif.o_busy   = (state_q != S_IDLE);
  assign sif.o_err    = err_q;
  assign sif.o_valid  = valid_q;
  assign sif.o_filt   = filt_q;
  assign sif.o_to_bus = bus_q;
endmodule

// File: tb/tb_stripes_sip_array_ctrl.sv
// Scoreboard bench for stripes_sip_array_ctrl: an integer activation model queues
// expected beats at start; a negedge monitor pops and compares them on each handshake.
module tb_stripes_sip_array_ctrl;
  localparam int N  = 16;
  localparam int Tn = 2;
  localparam int Tw = 2;
  localparam int Ti = 16;
  localparam int PW = 5;
  localparam int FW = 1;
  localparam longint SMAX = (64'sd1 <<< (N-1)) - 1;
  localparam longint SMIN = -(64'sd1 <<< (N-1));

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  stripes_sip_array_ctrl_if #(.N(N), .Tn(Tn), .Tw(Tw), .Ti(Ti), .PW(PW)) sif ();
  stripes_sip_array_ctrl #(.N(N), .Tn(Tn), .Tw(Tw), .Ti(Ti), .PW(PW), .ACC_W(2*N+4)) dut (
    .clk(clk), .reset(reset), .sif(sif)
  );

  typedef struct {
    logic [FW-1:0]   filt;
    logic [N*Tw-1:0] bus;
  } beat_t;

  beat_t              sb[$];
  beat_t              mon_e;
  int                 n_chk = 0;
  int                 n_err = 0;
  int                 beat_cnt = 0;
  int                 err_pulses = 0;
  logic [Tw*Ti-1:0]   planes [16];
  logic [N*Ti*Tn-1:0] syn;
  logic [N*Tn*Tw-1:0] nb;
  logic [N*Tw-1:0]    first_bus;
  logic               prev_v = 1'b0, prev_r = 1'b0;
  logic [FW-1:0]      prev_f;
  logic [N*Tw-1:0]    prev_b;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: rebuild each activation from its planes, then a plain integer dot product.
  function automatic void push_expected(input int p, input bit sg);
    for (int f = 0; f < Tn; f++) begin
      beat_t e;
      e.filt = FW'(f);
      e.bus  = '0;
      for (int w = 0; w < Tw; w++) begin
        longint s;
        s = longint'($signed(nb[(f*Tw+w)*N +: N]));
        for (int i = 0; i < Ti; i++) begin
          longint act;
          act = 0;
          for (int k = 0; k < p; k++)
            if (planes[k][w*Ti+i])
              act += (sg && k == 0) ? -(64'sd1 <<< (p-1)) : (64'sd1 <<< (p-1-k));
          s += act * longint'($signed(syn[(f*Ti+i)*N +: N]));
        end
        if (s > SMAX) s = SMAX;
        else if (s < SMIN) s = SMIN;
        e.bus[w*N +: N] = s[N-1:0];
      end
      sb.push_back(e);
    end
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      prev_v = 1'b0;
    end else begin
      if (sif.o_err) err_pulses++;
      if (prev_v && !prev_r && sif.o_valid) begin
        chk("hold_filt", 64'(sif.o_filt), 64'(prev_f));
        chk("hold_bus", 64'(sif.o_to_bus), 64'(prev_b));
      end
      if (sif.o_valid && sif.i_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'(sb.size()), 64'd1);
        end else begin
          mon_e = sb.pop_front();
          chk("beat_filt", 64'(sif.o_filt), 64'(mon_e.filt));
          chk("beat_bus", 64'(sif.o_to_bus), 64'(mon_e.bus));
          if (beat_cnt == 0) first_bus = sif.o_to_bus;
          beat_cnt++;
        end
      end
      prev_v = sif.o_valid;
      prev_r = sif.i_ready;
      prev_f = sif.o_filt;
      prev_b = sif.o_to_bus;
    end
  end

  task automatic run_job(input int p, input bit sg, input int gap_at, input int gap_len,
                         input int rdy_hold, input bit poke_start);
    int n;
    int err0;
    push_expected(p, sg);
    beat_cnt = 0;
    err0 = err_pulses;
    sif.i_precision = PW'(p);
    sif.i_signed    = sg;
    sif.i_synapses  = syn;
    sif.i_nbout     = nb;
    sif.i_ready     = (rdy_hold == 0);
    sif.i_start     = 1'b1;
    tick();
    sif.i_start = 1'b0;
    for (int k = 0; k < p; k++) begin
      if (k == gap_at)
        repeat (gap_len) begin
          sif.i_bits_valid = 1'b0;
          sif.i_bits = (Tw*Ti)'($urandom);
          tick();
        end
      sif.i_bits       = planes[k];
      sif.i_bits_valid = 1'b1;
      if (poke_start && k == 1) begin
        sif.i_start     = 1'b1;
        sif.i_precision = '0;
      end
      tick();
      sif.i_start     = 1'b0;
      sif.i_precision = PW'(p);
    end
    sif.i_bits_valid = 1'b0;
    if (gap_len == 0) chk("first_beat_latency", 64'(sif.o_valid), 64'd1);
    n = 0;
    while (!sif.o_valid && n < 30) begin tick(); n++; end
    chk("valid_seen", 64'(sif.o_valid), 64'd1);
    if (rdy_hold > 0) begin
      repeat (rdy_hold) tick();
      sif.i_ready = 1'b1;
    end
    n = 0;
    while (sif.o_busy && n < 40) begin tick(); n++; end
    chk("busy_drop", 64'(sif.o_busy), 64'd0);
    chk("valid_low", 64'(sif.o_valid), 64'd0);
    chk("beat_count", 64'(beat_cnt), 64'(Tn));
    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("no_err_pulse", 64'(err_pulses - err0), 64'd0);
    sb.delete();
    tick();
  endtask

  task automatic bad_start(input int p);
    sif.i_precision = PW'(p);
    sif.i_start = 1'b1;
    tick();
    sif.i_start = 1'b0;
    chk("err_pulse", 64'(sif.o_err), 64'd1);
    chk("err_busy", 64'(sif.o_busy), 64'd0);
    tick();
    chk("err_clear", 64'(sif.o_err), 64'd0);
    chk("err_busy_after", 64'(sif.o_busy), 64'd0);
  endtask

  task automatic clear_stim();
    for (int k = 0; k < 16; k++) planes[k] = '0;
    syn = '0;
    nb  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    sif.i_start = 1'b0; sif.i_precision = '0; sif.i_signed = 1'b0; sif.i_bits_valid = 1'b0;
    sif.i_bits = '0; sif.i_synapses = '0; sif.i_nbout = '0; sif.i_ready = 1'b1;
    clear_stim();
    repeat (3) tick();
    chk("rst_valid", 64'(sif.o_valid), 64'd0);
    chk("rst_busy", 64'(sif.o_busy), 64'd0);
    chk("rst_err", 64'(sif.o_err), 64'd0);
    chk("rst_bus", 64'(sif.o_to_bus), 64'd0);
    reset = 1'b0;
    tick();

    // Unsigned 0101 x 3 on lane 0 / window 0
    syn[N-1:0] = 16'd3;
    planes[1][0] = 1'b1; planes[3][0] = 1'b1;
    run_job(4, 1'b0, -1, 0, 0, 1'b0);
    chk("tp_unsigned", 64'(first_bus), 64'h0000_000F);

    // Signed 1011 (-5) x 3, without and with bias 20
    for (int k = 0; k < 4; k++) planes[k] = '0;
    planes[0][0] = 1'b1; planes[2][0] = 1'b1; planes[3][0] = 1'b1;
    run_job(4, 1'b1, -1, 0, 0, 1'b0);
    chk("tp_signed", 64'(first_bus), 64'h0000_FFF1);
    nb[N-1:0] = 16'd20;
    run_job(4, 1'b1, -1, 0, 0, 1'b0);
    chk("tp_signed_bias", 64'(first_bus), 64'h0000_0005);

    // Both saturation rails at full precision
    clear_stim();
    for (int k = 0; k < 16; k++) planes[k] = '1;
    for (int j = 0; j < Ti*Tn; j++) syn[j*N +: N] = 16'h7FFF;
    run_job(16, 1'b0, -1, 0, 0, 1'b0);
    chk("sat_pos", 64'(first_bus), 64'h7FFF_7FFF);
    for (int j = 0; j < Ti*Tn; j++) syn[j*N +: N] = 16'h8000;
    run_job(16, 1'b0, -1, 0, 0, 1'b0);
    chk("sat_neg", 64'(first_bus), 64'h8000_8000);

    // Input stall, output backpressure and a start poke during ACCUM
    clear_stim();
    syn[N-1:0] = 16'd3;
    planes[1][0] = 1'b1; planes[3][0] = 1'b1;
    run_job(4, 1'b0, 2, 3, 5, 1'b1);
    chk("tp_stalled", 64'(first_bus), 64'h0000_000F);

    bad_start(0);
    bad_start(17);

    for (int r = 0; r < 4; r++) begin
      int p;
      bit sg;
      p  = $urandom_range(1, 16);
      sg = 1'($urandom_range(0, 1));
      for (int k = 0; k < 16; k++) planes[k] = (Tw*Ti)'($urandom);
      for (int j = 0; j < (N*Ti*Tn)/32; j++) syn[j*32 +: 32] = $urandom;
      for (int j = 0; j < (N*Tn*Tw)/32; j++) nb[j*32 +: 32] = $urandom;
      run_job(p, sg, (p > 2) ? 1 : -1, (p > 2) ? 2 : 0, r, (p >= 2) && (r == 1));
    end

    // Reset while beat 1 is on the bus, then a clean run
    clear_stim();
    syn[N-1:0] = 16'd3;
    planes[1][0] = 1'b1; planes[3][0] = 1'b1;
    push_expected(4, 1'b0);
    beat_cnt = 0;
    sif.i_ready = 1'b0; sif.i_precision = PW'(4); sif.i_signed = 1'b0;
    sif.i_synapses = syn; sif.i_nbout = nb; sif.i_start = 1'b1;
    tick();
    sif.i_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sif.i_bits = planes[k]; sif.i_bits_valid = 1'b1;
      tick();
    end
    sif.i_bits_valid = 1'b0;
    sif.i_ready = 1'b1;
    tick();
    sif.i_ready = 1'b0;
    chk("pre_rst_filt", 64'(sif.o_filt), 64'd1);
    chk("pre_rst_valid", 64'(sif.o_valid), 64'd1);
    reset = 1'b1;
    #1;
    chk("abort_valid", 64'(sif.o_valid), 64'd0);
    chk("abort_busy", 64'(sif.o_busy), 64'd0);
    chk("abort_filt", 64'(sif.o_filt), 64'd0);
    chk("abort_bus", 64'(sif.o_to_bus), 64'd0);
    chk("abort_err", 64'(sif.o_err), 64'd0);
    sb.delete();
    tick(); tick();
    reset = 1'b0;
    sif.i_ready = 1'b1;
    repeat (3) tick();
    chk("post_rst_quiet", 64'(sif.o_valid), 64'd0);
    run_job(4, 1'b0, -1, 0, 0, 1'b0);
    chk("post_rst_run", 64'(first_bus), 64'h0000_000F);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/stripes_sip_array_ctrl.md
Name: stripes_sip_array_ctrl

Overview:
- Parametrised successor to the single-filter Stripes node slice.
- Tn filters x Tw windows of serial inner-product (SIP) units, each fed Ti bit-serial activations and Ti bit-parallel N-bit synapses.
- Owns its precision-counting FSM, input-stall handling, NBout bias add, output saturation, and a ready/valid drain of results onto the NBout bus, one filter per beat.
- Sits between the NBin/SB fetch logic and the NBout write port.

Parameters:
N, 16, synapse/activation/output word width (bits)
Tn, 4, filters (SIP rows); also number of drain beats
Tw, 16, windows (SIP columns)
Ti, 16, input lanes per SIP
PW, 5, precision field width; must satisfy 2^PW > N
ACC_W, 2*N+4, accumulator width; must be >= 2*N+clog2(Ti)

Ports:
clk  in  1  main clock
reset  in  1  asynchronous, active-high
i_start  in  1  start pulse; sampled only in IDLE
i_precision  in  PW  activation precision P, legal range 1..N
i_signed  in  1  1 = activations two's complement, 0 = unsigned
i_bits_valid  in  1  i_bits holds a valid bit-plane this cycle
i_bits  in  Tw*Ti  one activation bit per lane per window, MSB first; index w*Ti+i
i_synapses  in  N*Ti*Tn  signed synapses; index (f*Ti+i)*N, held stable during ACCUM
i_nbout  in  N*Tn*Tw  signed bias / partial sums; index (f*Tw+w)*N, sampled at start
o_busy  out  1  high outside IDLE
o_err  out  1  one-cycle pulse on a rejected start
o_valid  out  1  drain beat valid
i_ready  in  1  consumer accepts a beat when o_valid and i_ready are both high
o_filt  out  clog2(Tn) (min 1)  filter index of the current beat
o_to_bus  out  N*Tw  Tw saturated results for filter o_filt; index w*N

Behaviour:
Reset:
- All outputs 0; FSM in IDLE; accumulators, counters and latched controls cleared.
- Reset asserted mid-ACCUM or mid-DRAIN aborts immediately; no further beats are produced.

FSM IDLE:
- i_start with 1 <= P <= N: latch P, i_signed and i_nbout; clear all accumulators; bit counter k = 0; go to ACCUM next cycle.
- i_start with P = 0 or P > N: stay in IDLE; o_err = 1 for one cycle.

FSM ACCUM:
- Each cycle with i_bits_valid = 1:
  - partial(f,w) = sum over i of (i_bits[w*Ti+i] ? syn(f,i) : 0), sign-extended to ACC_W.
  - If k == 0 and i_signed = 1: acc = (acc<<1) - partial. Otherwise: acc = (acc<<1) + partial.
  - k increments.
- i_bits_valid = 0: accumulators and k hold (stall).
- When the P-th valid plane is consumed (k == P-1 and i_bits_valid = 1): go to DRAIN next cycle.
- i_start is ignored while busy (no o_err).

FSM DRAIN:
- Result r(f,w) = sat_N(acc(f,w) + sext(nbout(f,w))), saturating to the signed N-bit range [-2^(N-1), 2^(N-1)-1].
- Outputs are registered: o_valid rises the first cycle in DRAIN with o_filt = 0.
- While o_valid = 1 and i_ready = 0: o_to_bus and o_filt hold.
- On handshake: o_filt increments; the next beat is presented the following cycle with no bubble.
- After the handshake of beat Tn-1: o_valid = 0, return to IDLE.
- An i_start in that same cycle is not accepted; the earliest accepted start is the first cycle back in IDLE.

Latency:
- With continuous i_bits_valid and i_ready: start at cycle 0, planes at cycles 1..P, first beat at cycle P+1, last beat at cycle P+Tn.

Arithmetic:
- ACC_W guarantees no accumulator overflow for P <= N.
- Saturation is applied only after the bias add.
- Unsigned mode treats every plane as positive weight.

Test Plan:
- N=16, Tn=2, Tw=2, Ti=16; P=4, unsigned; lane 0 bits 0101 in window 0; syn(0,0)=3, all others 0; bias 0 -> beat 0 bus[15:0]=0x000F, bus[31:16]=0x0000; beat 1 all zero.
- Same stimulus with i_signed=1 and bits 1011 (-5) -> r(0,0)=0xFFF1 (-15); with bias(0,0)=20 -> 0x0005.
- P=16, unsigned, all bits 1, all syn=0x7FFF -> every result 0x7FFF; all syn=0x8000 -> 0x8000 (both saturation rails).
- Drop i_bits_valid for 3 cycles mid-ACCUM; hold i_ready=0 for 5 cycles on beat 0 -> results identical to the unstalled run; o_to_bus/o_filt stable while stalled; exactly Tn beats total.
- i_start with P=0, then with P=17 -> o_err one-cycle pulse each time, o_busy stays 0; i_start during ACCUM -> ignored, no o_err.
- Assert reset during DRAIN beat 1 -> all outputs 0 immediately; a subsequent legal start produces a correct, complete run.
